// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit feeder: FSM encoding and default timing.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_WRITE = 2'd2,
    ST_ACK   = 2'd3
  } tx_state_t;

  localparam int GUARD_CYCLES_DEF = 1024;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Upstream valid/ready byte stream into the transmit feeder.
interface uart_tx_feeder_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/uart_byte_fifo.sv
// Power-of-two circular byte buffer with registered count/ready/empty and a flush that drops contents.
module uart_byte_fifo #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  input  logic              i_flush,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W:0]   o_count,
  output logic              o_ready,
  output logic              o_empty,
  output logic              o_empty_nxt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] FULL_XOR = {1'b1, {ADDR_W{1'b0}}};

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_ready;
  logic              r_empty;
  logic [ADDR_W:0]   w_wr_nxt;
  logic [ADDR_W:0]   w_rd_nxt;
  logic              w_push;
  logic              w_pop;

  // Ready is the registered view, so a same-cycle pop never admits an extra push.
  assign w_push = i_push & r_ready;
  assign w_pop  = i_pop & ~r_empty & ~i_flush;

  always_comb begin
    w_wr_nxt = r_wr_ptr;
    w_rd_nxt = r_rd_ptr;
    if (i_flush) begin
      w_rd_nxt = r_wr_ptr;
    end else begin
      if (w_push) w_wr_nxt = r_wr_ptr + PTR_ONE;
      if (w_pop)  w_rd_nxt = r_rd_ptr + PTR_ONE;
    end
  end

  assign o_empty_nxt = (w_wr_nxt == w_rd_nxt);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b1;
      r_empty  <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_wr_nxt - w_rd_nxt;
      r_ready  <= ((w_wr_nxt ^ w_rd_nxt) != FULL_XOR);
      r_empty  <= o_empty_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush && !i_rst) r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign o_count = r_count;
  assign o_ready = r_ready;
  assign o_empty = r_empty;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers upstream bytes and issues one WRN strobe per byte once the transmitter has been idle
// for a full guard interval, so a new frame never clips the previous stop bit.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int ADDR_W       = 4,
  parameter int GUARD_CYCLES = GUARD_CYCLES_DEF,
  parameter int DATA_W       = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  uart_tx_feeder_if.slave   s_if,
  input  logic              i_flush,
  input  logic              i_buffer_empty,
  output logic [DATA_W-1:0] o_din,
  output logic              o_wrn,
  output logic [ADDR_W:0]   o_fifo_count,
  output logic              o_tx_idle
);

  localparam int GUARD_W = $clog2(GUARD_CYCLES + 1);
  localparam logic [GUARD_W-1:0] GUARD_MAX = GUARD_W'(GUARD_CYCLES);
  localparam logic [GUARD_W-1:0] GUARD_ONE = GUARD_W'(1);

  tx_state_t         r_state;
  tx_state_t         w_state_nxt;
  logic [GUARD_W-1:0] r_guard;
  logic              r_ack_wait;
  logic              w_ack_wait_nxt;
  logic              r_wrn;
  logic [DATA_W-1:0] r_din;
  logic              r_tx_idle;
  logic              w_guard_ok;
  logic              w_pop;
  logic              w_fifo_ready;
  logic              w_fifo_empty;
  logic              w_fifo_empty_nxt;
  logic [DATA_W-1:0] w_head;
  logic [ADDR_W:0]   w_count;

  uart_byte_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (s_if.s_valid),
    .i_data      (s_if.s_data),
    .i_pop       (w_pop),
    .i_flush     (i_flush),
    .o_data      (w_head),
    .o_count     (w_count),
    .o_ready     (w_fifo_ready),
    .o_empty     (w_fifo_empty),
    .o_empty_nxt (w_fifo_empty_nxt)
  );

  // BUFFER_EMPTY rises before the stop bit finishes; require a long unbroken idle run.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_buffer_empty) begin
      r_guard <= '0;
    end else if (r_guard != GUARD_MAX) begin
      r_guard <= r_guard + GUARD_ONE;
    end
  end

  assign w_guard_ok = (r_guard == GUARD_MAX);

  always_comb begin
    w_state_nxt    = r_state;
    w_pop          = 1'b0;
    w_ack_wait_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) w_state_nxt = ST_GUARD;
      end
      ST_GUARD: begin
        if (w_fifo_empty) begin
          w_state_nxt = ST_IDLE;
        end else if (w_guard_ok && !i_flush) begin
          w_state_nxt = ST_WRITE;
          w_pop       = 1'b1;
        end
      end
      ST_WRITE: begin
        w_state_nxt = ST_ACK;
      end
      ST_ACK: begin
        // No retry: a transmitter that never drops BUFFER_EMPTY still counts as sent.
        if (!i_buffer_empty || r_ack_wait) w_state_nxt = ST_GUARD;
        else                               w_ack_wait_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_ack_wait <= 1'b0;
      r_wrn      <= 1'b1;
      r_din      <= '0;
      r_tx_idle  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ack_wait <= w_ack_wait_nxt;
      r_wrn      <= ~w_pop;
      if (w_pop) r_din <= w_head;
      r_tx_idle  <= w_fifo_empty_nxt && i_buffer_empty &&
                    ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_GUARD));
    end
  end

  assign s_if.s_ready = w_fifo_ready;
  assign o_din        = r_din;
  assign o_wrn        = r_wrn;
  assign o_fifo_count = w_count;
  assign o_tx_idle    = r_tx_idle;

endmodule
